// File: rtl/acc_int_adder_pkg.sv
// Shared constants and helpers for the exact adder and its sibling adder variants.
// Holds the prefix-tree depth calculation so every variant sizes its tree identically.
package acc_int_adder_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int MAX_WIDTH     = 64;

   // Number of Kogge-Stone levels needed to span n bits: ceil(log2(n)), 0 for n=1.
   function automatic int ks_levels(input int n);
      int l;
      l = 0;
      for (int k = 0; k < 7; k++) begin
         if ((1 << k) < n) begin
            l = k + 1;
         end
      end
      return l;
   endfunction

endpackage

// File: rtl/acc_int_adder_ks_prefix_cell.sv
// Kogge-Stone group generate/propagate combine cell.
// The high group absorbs the low group: G = Gh | (Ph & Gl), P = Ph & Pl.
module ks_prefix_cell (
   input  logic i_gh,
   input  logic i_ph,
   input  logic i_gl,
   input  logic i_pl,
   output logic o_g,
   output logic o_p
);

   assign o_g = i_gh | (i_ph & i_gl);
   assign o_p = i_ph & i_pl;

endmodule

// File: rtl/acc_int_adder.sv
// Exact N-bit adder with an explicit Kogge-Stone carry network and a registered result.
// Reference datapath for the approximate and clock-gated adder wrappers.
module acc_int_adder
   import acc_int_adder_pkg::*;
#(
   parameter int DATA_PATH_BITWIDTH = DEFAULT_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   input  logic [DATA_PATH_BITWIDTH-1:0] a,
   input  logic [DATA_PATH_BITWIDTH-1:0] b,
   output logic [DATA_PATH_BITWIDTH-1:0] c,
   output logic                          cout,
   output logic                          out_valid
);

   localparam int N    = DATA_PATH_BITWIDTH;
   localparam int LVLS = ks_levels(N);

   logic [N-1:0] w_sum;
   logic         w_cout;
   logic         w_unused_p;

   logic [N-1:0] r_c;
   logic         r_cout;
   logic         r_out_valid;

   // Level 0 holds per-bit (g,p); level k holds groups spanning 2^k bits ending at each index.
   genvar gk, gi;
   generate
      for (gk = 0; gk <= LVLS; gk++) begin : g_lvl
         logic [N-1:0] w_g;
         logic [N-1:0] w_p;

         if (gk == 0) begin : g_init
            assign w_g = a & b;
            assign w_p = a ^ b;
         end else begin : g_tree
            localparam int D = 1 << (gk - 1);
            for (gi = 0; gi < N; gi++) begin : g_bit
               if (gi >= D) begin : g_cell
                  ks_prefix_cell u_cell (
                     .i_gh (g_lvl[gk-1].w_g[gi]),
                     .i_ph (g_lvl[gk-1].w_p[gi]),
                     .i_gl (g_lvl[gk-1].w_g[gi-D]),
                     .i_pl (g_lvl[gk-1].w_p[gi-D]),
                     .o_g  (w_g[gi]),
                     .o_p  (w_p[gi])
                  );
               end else begin : g_pass
                  // Partner index falls below bit 0: combine with identity (G=0, P=1).
                  assign w_g[gi] = g_lvl[gk-1].w_g[gi];
                  assign w_p[gi] = g_lvl[gk-1].w_p[gi];
               end
            end
         end
      end

      // Carry into bit i is the group generate of bits [i-1:0]; carry-in to bit 0 is 0.
      if (N == 1) begin : g_sum_one
         assign w_sum = g_lvl[0].w_p;
      end else begin : g_sum_wide
         assign w_sum = g_lvl[0].w_p ^ {g_lvl[LVLS].w_g[N-2:0], 1'b0};
      end
   endgenerate

   assign w_cout     = g_lvl[LVLS].w_g[N-1];
   assign w_unused_p = ^g_lvl[LVLS].w_p;

   // Result registers only load on accepted operands, so X on idle cycles never reaches c.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_c         <= '0;
         r_cout      <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= in_valid;
         if (in_valid) begin
            r_c    <= w_sum;
            r_cout <= w_cout;
         end
      end
   end

   assign c         = r_c;
   assign cout      = r_cout;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_acc_int_adder.sv
// Directed and randomized checks of acc_int_adder at widths 32, 13 and 1.
// Expected sums come from hand-computed vectors and a behavioural a+b model.
module tb_acc_int_adder;

   logic        clk;
   logic        rst;
   logic        iv;

   logic [31:0] a32, b32, c32;
   logic        co32, ov32;
   logic [12:0] a13, b13, c13;
   logic        co13, ov13;
   logic [0:0]  a1, b1, c1;
   logic        co1, ov1;

   int errors;
   int checks;

   acc_int_adder #(.DATA_PATH_BITWIDTH(32)) u_dut32 (
      .clk(clk), .rst(rst), .in_valid(iv), .a(a32), .b(b32),
      .c(c32), .cout(co32), .out_valid(ov32)
   );

   acc_int_adder #(.DATA_PATH_BITWIDTH(13)) u_dut13 (
      .clk(clk), .rst(rst), .in_valid(iv), .a(a13), .b(b13),
      .c(c13), .cout(co13), .out_valid(ov13)
   );

   acc_int_adder #(.DATA_PATH_BITWIDTH(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(iv), .a(a1), .b(b1),
      .c(c1), .cout(co1), .out_valid(ov1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      iv  = 1'b1;
      a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF;
      a13 = '1; b13 = '1; a1 = 1'b1; b1 = 1'b1;
      tick();
      tick();
      checks++;
      if (c32 !== 32'h0 || co32 !== 1'b0 || ov32 !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold: got c=%h cout=%b ov=%b, want c=0 cout=0 ov=0", c32, co32, ov32);
      end
      checks++;
      if (c13 !== 13'h0 || ov13 !== 1'b0 || c1 !== 1'b0 || ov1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold_narrow: got c13=%h ov13=%b c1=%b ov1=%b, want all 0", c13, ov13, c1, ov1);
      end
      rst = 1'b1;
      a32 = 32'd3; b32 = 32'd4;
      a13 = 13'd3; b13 = 13'd4; a1 = 1'b0; b1 = 1'b1;
      tick();
      checks++;
      if (c32 !== 32'd7 || co32 !== 1'b0 || ov32 !== 1'b1) begin
         errors++;
         $display("FAIL first_capture: got c=%h cout=%b ov=%b, want c=7 cout=0 ov=1", c32, co32, ov32);
      end
      $display("reset: released, first capture c=%0d ov=%b", c32, ov32);
   endtask

   task automatic test_wrap();
      logic [31:0] va [2];
      logic [31:0] vb [2];
      va[0] = 32'hFFFF_FFFF; vb[0] = 32'h0000_0001;
      va[1] = 32'h8000_0000; vb[1] = 32'h8000_0000;
      for (int i = 0; i < 2; i++) begin
         iv = 1'b1; a32 = va[i]; b32 = vb[i];
         tick();
         checks++;
         if (c32 !== 32'h0 || co32 !== 1'b1 || ov32 !== 1'b1) begin
            errors++;
            $display("FAIL wrap%0d: got c=%h cout=%b ov=%b, want c=00000000 cout=1 ov=1", i, c32, co32, ov32);
         end
         $display("wrap: a=%h b=%h -> c=%h cout=%b", va[i], vb[i], c32, co32);
      end
   endtask

   task automatic test_carry_chain();
      logic [31:0] va [3];
      logic [31:0] vb [3];
      logic [31:0] ec [3];
      logic        eo [3];
      va[0] = 32'h7FFF_FFFF; vb[0] = 32'h0000_0001; ec[0] = 32'h8000_0000; eo[0] = 1'b0;
      va[1] = 32'hAAAA_AAAA; vb[1] = 32'h5555_5555; ec[1] = 32'hFFFF_FFFF; eo[1] = 1'b0;
      va[2] = 32'hFFFF_FFFF; vb[2] = 32'hFFFF_FFFF; ec[2] = 32'hFFFF_FFFE; eo[2] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         iv = 1'b1; a32 = va[i]; b32 = vb[i];
         tick();
         checks++;
         if (c32 !== ec[i] || co32 !== eo[i] || ov32 !== 1'b1) begin
            errors++;
            $display("FAIL chain%0d: got c=%h cout=%b ov=%b, want c=%h cout=%b ov=1",
                     i, c32, co32, ov32, ec[i], eo[i]);
         end
         $display("chain: a=%h b=%h -> c=%h cout=%b", va[i], vb[i], c32, co32);
      end
   endtask

   task automatic test_hold();
      iv = 1'b1; a32 = 32'd3; b32 = 32'd4;
      tick();
      iv = 1'b0; a32 = 'x; b32 = 'x; a13 = 'x; b13 = 'x; a1 = 'x; b1 = 'x;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (c32 !== 32'd7 || co32 !== 1'b0 || ov32 !== 1'b0) begin
            errors++;
            $display("FAIL hold%0d: got c=%h cout=%b ov=%b, want c=7 cout=0 ov=0", i, c32, co32, ov32);
         end
         $display("hold: cycle %0d c=%0d ov=%b", i, c32, ov32);
      end
      a13 = '0; b13 = '0; a1 = '0; b1 = '0;
   endtask

   task automatic test_async_reset();
      iv = 1'b1; a32 = 32'd5; b32 = 32'd6;
      tick();
      checks++;
      if (c32 !== 32'd11 || ov32 !== 1'b1) begin
         errors++;
         $display("FAIL pre_async: got c=%h ov=%b, want c=b ov=1", c32, ov32);
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (c32 !== 32'h0 || co32 !== 1'b0 || ov32 !== 1'b0) begin
         errors++;
         $display("FAIL async_clear: got c=%h cout=%b ov=%b, want c=0 cout=0 ov=0", c32, co32, ov32);
      end
      tick();
      checks++;
      if (c32 !== 32'h0 || ov32 !== 1'b0) begin
         errors++;
         $display("FAIL async_held: got c=%h ov=%b, want c=0 ov=0", c32, ov32);
      end
      rst = 1'b1; iv = 1'b0;
      tick();
      checks++;
      if (c32 !== 32'h0 || ov32 !== 1'b0) begin
         errors++;
         $display("FAIL post_release_idle: got c=%h ov=%b, want c=0 ov=0", c32, ov32);
      end
      iv = 1'b1; a32 = 32'd1; b32 = 32'd2;
      tick();
      checks++;
      if (c32 !== 32'd3 || ov32 !== 1'b1) begin
         errors++;
         $display("FAIL post_release_capture: got c=%h ov=%b, want c=3 ov=1", c32, ov32);
      end
      $display("async_reset: cleared mid-cycle, recovered c=%0d", c32);
   endtask

   task automatic test_random();
      logic [32:0] m32;
      logic [13:0] m13;
      logic [1:0]  m1;
      logic        v;
      int          bad;
      bad = 0;
      m32 = '0; m13 = '0; m1 = '0;
      for (int n = 0; n < 3000; n++) begin
         v = (n == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
         iv = v;
         if (v) begin
            a32 = $urandom; b32 = $urandom;
            a13 = 13'($urandom); b13 = 13'($urandom);
            a1  = 1'($urandom); b1 = 1'($urandom);
            m32 = {1'b0, a32} + {1'b0, b32};
            m13 = {1'b0, a13} + {1'b0, b13};
            m1  = {1'b0, a1} + {1'b0, b1};
         end else begin
            a32 = 'x; b32 = 'x; a13 = 'x; b13 = 'x; a1 = 'x; b1 = 'x;
         end
         tick();
         checks++;
         if ({co32, c32} !== m32 || ov32 !== v) begin
            errors++; bad++;
            $display("FAIL rand32 #%0d: got cout,c=%h ov=%b, want %h ov=%b", n, {co32, c32}, ov32, m32, v);
         end
         checks++;
         if ({co13, c13} !== m13 || ov13 !== v) begin
            errors++; bad++;
            $display("FAIL rand13 #%0d: got cout,c=%h ov=%b, want %h ov=%b", n, {co13, c13}, ov13, m13, v);
         end
         checks++;
         if ({co1, c1} !== m1 || ov1 !== v) begin
            errors++; bad++;
            $display("FAIL rand1 #%0d: got cout,c=%b ov=%b, want %b ov=%b", n, {co1, c1}, ov1, m1, v);
         end
      end
      iv = 1'b0;
      $display("random: 3000 cycles at N=32/13/1, %0d mismatching comparisons", bad);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b0; iv = 1'b0;
      a32 = '0; b32 = '0; a13 = '0; b13 = '0; a1 = '0; b1 = '0;
      test_reset();
      test_wrap();
      test_carry_chain();
      test_hold();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
